// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch front end with redirect kill and a decode skid
//            register, driving a synchronous 1-cycle-latency instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pcsrc,
    input  logic             stall,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst_d,
    output logic [31:0]      pc_d,
    output logic             inst_valid_d,
    output logic [CNT_W-1:0] redirect_count,
    output logic             misaligned
);

    typedef enum logic [1:0] {
        KILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [31:0]      r_pcF;
    logic [31:0]      r_pcD;
    logic [31:0]      r_skid;
    logic [CNT_W-1:0] r_redirectCount;
    logic             r_misaligned;

    logic             w_redir;
    logic             w_hold;

    assign w_redir = (pcsrc == 2'b11);
    assign w_hold  = stall | (pcsrc == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= KILL;
            r_pcF           <= RESET_PC;
            r_pcD           <= RESET_PC;
            r_skid          <= NOP_INST;
            r_redirectCount <= '0;
            r_misaligned    <= 1'b0;
        end else if (w_redir) begin
            // Whatever the memory returns next cycle is wrong-path; bubble it.
            r_state      <= KILL;
            r_pcF        <= {redirect_target[31:2], 2'b00};
            r_misaligned <= r_misaligned | (redirect_target[1:0] != 2'b00);
            if (r_redirectCount != c_cntMax) begin
                r_redirectCount <= r_redirectCount + c_cntOne;
            end
        end else if (w_hold) begin
            // Only the first stalled cycle of a live instruction captures it;
            // imem_addr is frozen, so the memory replays the next address.
            if (r_state == RUN) begin
                r_state <= HOLD;
                r_skid  <= imem_rdata;
            end
        end else begin
            r_state <= RUN;
            r_pcD   <= r_pcF;
            r_pcF   <= r_pcF + 32'd4;
        end
    end

    always_comb begin
        inst_valid_d = 1'b0;
        inst_d       = NOP_INST;
        case (r_state)
            RUN: begin
                inst_valid_d = 1'b1;
                inst_d       = imem_rdata;
            end
            HOLD: begin
                inst_valid_d = 1'b1;
                inst_d       = r_skid;
            end
            default: begin
                inst_valid_d = 1'b0;
                inst_d       = NOP_INST;
            end
        endcase
    end

    assign imem_addr      = r_pcF;
    assign pc_d           = r_pcD;
    assign redirect_count = r_redirectCount;
    assign misaligned     = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: directed vector table, async
//            reset, randomized stream against a reference model, saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_2000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          CNT_W    = 16;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       pcsrc = 2'b01;
    logic             stall = 1'b0;
    logic [31:0]      redirect_target = 32'h0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      inst_d;
    logic [31:0]      pc_d;
    logic             inst_valid_d;
    logic [CNT_W-1:0] redirect_count;
    logic             misaligned;

    int nChecks = 0;
    int nFails  = 0;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pcsrc           (pcsrc),
        .stall           (stall),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .inst_d          (inst_d),
        .pc_d            (pc_d),
        .inst_valid_d    (inst_valid_d),
        .redirect_count  (redirect_count),
        .misaligned      (misaligned)
    );

    always #5 clk = ~clk;

    // Memory contents: every word holds its own byte address.
    function automatic logic [31:0] memOf(input logic [31:0] a);
        return a;
    endfunction

    always @(posedge clk) imem_rdata <= memOf(imem_addr);

    typedef struct {
        logic [1:0]  pcsrc;
        logic        stall;
        logic [31:0] tgt;
        logic        eValid;
        logic [31:0] ePcD;
        logic [31:0] eInst;
        logic [31:0] eAddr;
        logic [15:0] eCnt;
        logic        eMis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] ps, input logic st, input logic [31:0] tg,
                                input logic v, input logic [31:0] pd, input logic [31:0] in,
                                input logic [31:0] ad, input logic [15:0] cn, input logic mi);
        vec_t r;
        r.pcsrc = ps; r.stall = st; r.tgt = tg; r.eValid = v; r.ePcD = pd;
        r.eInst = in; r.eAddr = ad; r.eCnt = cn; r.eMis = mi;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic v, input logic [31:0] pd,
                            input logic [31:0] inst, input logic [31:0] addr,
                            input logic [15:0] cnt, input logic mis);
        check({tag, ".valid"}, {31'b0, inst_valid_d}, {31'b0, v});
        check({tag, ".pc_d"}, pc_d, pd);
        check({tag, ".inst_d"}, inst_d, inst);
        check({tag, ".imem_addr"}, imem_addr, addr);
        check({tag, ".count"}, {16'b0, redirect_count}, {16'b0, cnt});
        check({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, mis});
    endtask

    // Reference model state: decode slot and next fetch address.
    logic        mValid;
    logic [31:0] mPcD;
    logic [31:0] mFpc;
    int          mCnt;
    logic        mMis;

    initial begin
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h2000, 32'h2000, 32'h2004, 0, 0));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h2004, 32'h2004, 32'h2008, 0, 0));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h2008, 32'h2008, 32'h200C, 0, 0));
        vecs.push_back(mk(2'b01, 1'b1, 32'h0,        1, 32'h2008, 32'h2008, 32'h200C, 0, 0));
        vecs.push_back(mk(2'b01, 1'b1, 32'h0,        1, 32'h2008, 32'h2008, 32'h200C, 0, 0));
        vecs.push_back(mk(2'b01, 1'b1, 32'h0,        1, 32'h2008, 32'h2008, 32'h200C, 0, 0));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h200C, 32'h200C, 32'h2010, 0, 0));
        vecs.push_back(mk(2'b00, 1'b0, 32'h0,        1, 32'h200C, 32'h200C, 32'h2010, 0, 0));
        vecs.push_back(mk(2'b10, 1'b0, 32'h0,        1, 32'h2010, 32'h2010, 32'h2014, 0, 0));
        vecs.push_back(mk(2'b11, 1'b0, 32'h3000,     0, 32'h2010, NOP_INST, 32'h3000, 1, 0));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h3000, 32'h3000, 32'h3004, 1, 0));
        vecs.push_back(mk(2'b01, 1'b1, 32'h0,        1, 32'h3000, 32'h3000, 32'h3004, 1, 0));
        vecs.push_back(mk(2'b11, 1'b1, 32'h4000,     0, 32'h3000, NOP_INST, 32'h4000, 2, 0));
        vecs.push_back(mk(2'b01, 1'b1, 32'h0,        0, 32'h3000, NOP_INST, 32'h4000, 2, 0));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h4000, 32'h4000, 32'h4004, 2, 0));
        vecs.push_back(mk(2'b11, 1'b0, 32'h3002,     0, 32'h4000, NOP_INST, 32'h3000, 3, 1));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h3000, 32'h3000, 32'h3004, 3, 1));
        vecs.push_back(mk(2'b11, 1'b0, 32'h5000,     0, 32'h3000, NOP_INST, 32'h5000, 4, 1));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h5000, 32'h5000, 32'h5004, 4, 1));
        vecs.push_back(mk(2'b11, 1'b0, 32'hFFFFFFFF, 0, 32'h5000, NOP_INST, 32'hFFFFFFFC, 5, 1));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0, 5, 1));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,        1, 32'h0, 32'h0, 32'h4, 5, 1));
        vecs.push_back(mk(2'b01, 1'b1, 32'h0,        1, 32'h0, 32'h0, 32'h4, 5, 1));

        // Reset asserted at time 0, release just after the first counted edge.
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkAll("edge1", 1'b0, RESET_PC, NOP_INST, RESET_PC, 16'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            pcsrc           = vecs[i].pcsrc;
            stall           = vecs[i].stall;
            redirect_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            checkAll($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].ePcD, vecs[i].eInst,
                     vecs[i].eAddr, vecs[i].eCnt, vecs[i].eMis);
        end

        // Asynchronous reset while in HOLD, between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        checkAll("asyncReset", 1'b0, RESET_PC, NOP_INST, RESET_PC, 16'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        mValid = 1'b0; mPcD = RESET_PC; mFpc = RESET_PC; mCnt = 0; mMis = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [1:0]  ps;
            logic        st;
            logic [31:0] tg;
            ps = 2'($urandom_range(0, 3));
            st = ($urandom_range(0, 3) == 0);
            tg = $urandom;
            if ($urandom_range(0, 63) != 0) tg[1:0] = 2'b00;
            pcsrc = ps; stall = st; redirect_target = tg;
            @(posedge clk);
            #1;
            if (ps == 2'b11) begin
                mValid = 1'b0;
                mFpc   = tg & 32'hFFFF_FFFC;
                if (mCnt < CNT_MAX) mCnt++;
                mMis   = mMis | (tg[1:0] != 2'b00);
            end else if (!(st || ps == 2'b00)) begin
                mValid = 1'b1;
                mPcD   = mFpc;
                mFpc   = mFpc + 32'd4;
            end
            checkAll($sformatf("rand%0d", c), mValid, mPcD,
                     mValid ? memOf(mPcD) : NOP_INST, mFpc, 16'(mCnt), mMis);
        end

        // Saturation: 2^CNT_W + 3 back-to-back redirects from reset.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        pcsrc = 2'b11; stall = 1'b0; redirect_target = 32'h6000;
        repeat (CNT_MAX - 1) @(posedge clk);
        #1;
        check("count.preSat", {16'b0, redirect_count}, CNT_MAX - 1);
        repeat (5) @(posedge clk);
        #1;
        check("count.sat", {16'b0, redirect_count}, CNT_MAX);
        check("count.satValid", {31'b0, inst_valid_d}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end. It consumes the PC-select and stall controls that the control unit produces, and drives a synchronous instruction memory with 1-cycle read latency. It presents a decode-stage instruction/PC pair with a valid flag. It kills wrong-path fetches after a redirect and holds the decode instruction stable across stalls using a skid register.

Parameters:
RESET_PC, 32'h0000_2000, byte address of the first fetch after reset
NOP_INST, 32'h0000_0013, instruction driven on inst_d when inst_valid_d=0
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
pcsrc  in  2  00 hold/replay, 01 PC+4, 10 treated as 01, 11 redirect to redirect_target
stall  in  1  decode cannot accept the current instruction
redirect_target  in  32  byte target, sampled when pcsrc=11
imem_addr  out  32  fetch byte address (= pc_f register)
imem_rdata  in  32  instruction for the imem_addr presented in the previous cycle
inst_d  out  32  decode-stage instruction
pc_d  out  32  decode-stage PC
inst_valid_d  out  1  inst_d/pc_d hold a real instruction
redirect_count  out  CNT_W  number of redirects taken, saturating
misaligned  out  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Signal definitions: hold = stall | (pcsrc==00); redir = (pcsrc==11). redir has priority over hold.
- Registers: pc_f, pc_d, skid, state, redirect_count, misaligned.
- States: KILL, RUN, HOLD.
  - Reset state is KILL.
- Reset values (applied immediately on rst_n low, no clock edge needed):
  - pc_f = imem_addr = RESET_PC
  - pc_d = RESET_PC
  - skid = NOP_INST
  - inst_valid_d = 0, inst_d = NOP_INST
  - redirect_count = 0, misaligned = 0
- Outputs by state:
  - KILL: inst_valid_d=0, inst_d=NOP_INST.
  - RUN: inst_valid_d=1, inst_d=imem_rdata.
  - HOLD: inst_valid_d=1, inst_d=skid.
  - pc_d is always the registered value.
- Transitions (any state):
  - redir → KILL:
    - pc_f <= {redirect_target[31:2],2'b00}
    - pc_d unchanged
    - redirect_count += 1, saturating at all-ones
    - misaligned <= misaligned | (redirect_target[1:0]!=0)
  - else hold:
    - KILL stays KILL; pc_f and pc_d unchanged.
    - RUN → HOLD; skid <= imem_rdata; pc_f and pc_d unchanged.
    - HOLD stays HOLD; skid and PCs unchanged.
  - else (advance) → RUN from any state: pc_d <= pc_f, pc_f <= pc_f + 4 (32-bit wrap, 0xFFFF_FFFC → 0).
- Latency:
  - A fetch address presented in cycle n appears on inst_d in cycle n+1.
  - After reset release, the first valid instruction (pc_d=RESET_PC) appears on the 2nd clock edge.
  - After a redirect, exactly one bubble precedes the target instruction when there is no stall.
- imem_addr holds its value during HOLD/KILL+hold, so the memory re-reads the same address. On leaving HOLD, imem_rdata therefore corresponds to the new pc_d with no skip and no duplicate.
- A redirect in HOLD discards the skid contents. A stall during a kill bubble extends the bubble; nothing is consumed.
- Reset asserted mid-operation: all registers take their reset values asynchronously. Any in-flight memory data is ignored because the state is KILL.

Test Plan:
- Reset release, pcsrc=01, stall=0, memory returns rdata=addr:
  - edge1: inst_valid_d=0, inst_d=0x13, imem_addr=0x2000.
  - edge2: pc_d=0x2000, inst_d=0x2000.
  - edge3: pc_d=0x2004.
- Steady stream, stall=1 for 3 cycles while pc_d=0x2008:
  - inst_d=0x2008 and pc_d=0x2008 are held for all 3 cycles; imem_addr=0x200C held.
  - Next cycle pc_d=0x200C; no skipped or duplicate PC.
- pcsrc=11, redirect_target=0x3000 while pc_d=0x2004:
  - Next cycle inst_valid_d=0, inst_d=0x13.
  - Following cycle pc_d=0x3000, valid=1; redirect_count=1.
- pcsrc=11 and stall=1 in the same cycle during HOLD: redirect wins. One bubble, then pc_d=0x4000 for target 0x4000.
- Redirect target 0x3002: imem_addr=0x3000, misaligned=1. misaligned stays 1 through later aligned redirects until rst_n low.
- rst_n driven low mid-HOLD, between clock edges: all outputs take reset values immediately (pc_d=0x2000, inst_valid_d=0, redirect_count=0).
- Force 2^CNT_W+3 redirects: redirect_count saturates at 0xFFFF.
